alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two requesters (port 0: execute unit; port 1: address/stack-pointer unit) using round-robin arbitration.
- Sequences each operation through a fixed flow: issue, settle, capture, acknowledge.
- Drives the ALU operand, function and flag-update inputs, and returns the registered result plus a flag snapshot to the granted requester.
- Sits between the control unit and the ALU; it is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between two requesters (port 0: execute unit, port 1:
// address/stack-pointer unit) with round-robin arbitration. Each granted
// operation runs IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE.
//
// Handshake: reqN is a level request held until ackN. ackN is a one-cycle
// pulse. result is valid while ackN is high. flags is loaded at the end of
// the ACK cycle and holds until the next ACK. A req still high after its ack
// counts as a new request.
//
// Optional feature (macro ALU_DIV_GUARD_EN): a grant with func=3'b011 and
// b=0 goes straight to ACK with result=all ones and flags=4'b0010. The ALU
// inputs are left untouched for that grant.
//
// Ports:
//   ALU_clk, ALU_rst          clock, async active-high reset
//   req*/func*/a*/b*/upd*     requester inputs (ports 0 and 1)
//   ack0/ack1                 completion pulses
//   result, flags             captured ALU result and {Z,S,V,C} snapshot
//   busy                      high whenever the FSM is not in IDLE
//   alu_x/alu_y/alu_func      ALU operand and function drive
//   alu_update                ALU flag-update strobe (CAPTURE only)
//   alu_z, alu_zero..carry    ALU result and flag outputs
//   dbg_state                 current FSM state encoding
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              ALU_clk,
    input  logic              ALU_rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [2:0]        func0,
    input  logic [2:0]        func1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic              upd0,
    input  logic              upd1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              busy,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_func,
    output logic              alu_update,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_ovf,
    input  logic              alu_carry,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                gnt_q, gnt_d;
    logic                upd_q, upd_d;
    logic                guard_q, guard_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [2:0]          func_q, func_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [3:0]          flags_q, flags_d;

    logic                grant_valid;
    logic                grant_id;
    logic [2:0]          sel_func;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                sel_upd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        upd_d       = upd_q;
        guard_d     = guard_q;
        x_d         = x_q;
        y_d         = y_q;
        func_d      = func_q;
        result_d    = result_q;
        flags_d     = flags_q;
        grant_valid = 1'b0;
        grant_id    = 1'b0;

        // Contested cycle goes to the port that did not win last time.
        if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_id    = ~last_q;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end

        sel_func = grant_id ? func1 : func0;
        sel_a    = grant_id ? a1    : a0;
        sel_b    = grant_id ? b1    : b0;
        sel_upd  = grant_id ? upd1  : upd0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    gnt_d   = grant_id;
                    upd_d   = sel_upd;
                    guard_d = 1'b0;
                    cnt_d   = 4'(HOLD_CYCLES);
                    x_d     = sel_a;
                    y_d     = sel_b;
                    func_d  = sel_func;
                    state_d = S_ISSUE;
`ifdef ALU_DIV_GUARD_EN
                    // Divide by zero never reaches the ALU.
                    if (sel_func == 3'b011 && sel_b == '0) begin
                        guard_d  = 1'b1;
                        x_d      = x_q;
                        y_d      = y_q;
                        func_d   = func_q;
                        result_d = '1;
                        state_d  = S_ACK;
                    end
`endif
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = alu_z;
                state_d  = S_ACK;
            end
            S_ACK: begin
                // The ALU flags already reflect the update strobed in CAPTURE.
                flags_d = guard_q ? 4'b0010
                                  : {alu_zero, alu_sign, alu_ovf, alu_carry};
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ALU_clk or posedge ALU_rst) begin
        if (ALU_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            upd_q    <= 1'b0;
            guard_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            func_q   <= 3'd0;
            result_q <= '0;
            flags_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            upd_q    <= upd_d;
            guard_q  <= guard_d;
            x_q      <= x_d;
            y_q      <= y_d;
            func_q   <= func_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign ack0       = (state_q == S_ACK) && !gnt_q;
    assign ack1       = (state_q == S_ACK) &&  gnt_q;
    assign alu_update = (state_q == S_CAPTURE) && upd_q;
    assign busy       = (state_q != S_IDLE);
    assign result     = result_q;
    assign flags      = flags_q;
    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign alu_func   = func_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int DW   = 8;
    localparam int HOLD = 1;

    typedef struct packed {
        logic [2:0]    f;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          u;
    } op_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req0, req1, upd0, upd1;
    logic [2:0]    func0, func1;
    logic [DW-1:0] a0, a1, b0, b1;
    logic          ack0, ack1, busy, alu_update;
    logic [DW-1:0] result, alu_x, alu_y, alu_z;
    logic [3:0]    flags;
    logic [2:0]    alu_func;
    logic [1:0]    dbg_state;
    logic [11:0]   alu_out;
    logic [3:0]    alu_flag_reg = 4'd0;

    alu_arbiter #(.DATA_W(DW), .HOLD_CYCLES(HOLD)) dut (
        .ALU_clk(clk), .ALU_rst(rst),
        .req0(req0), .req1(req1), .func0(func0), .func1(func1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .upd0(upd0), .upd1(upd1),
        .ack0(ack0), .ack1(ack1), .result(result), .flags(flags), .busy(busy),
        .alu_x(alu_x), .alu_y(alu_y), .alu_func(alu_func), .alu_update(alu_update),
        .alu_z(alu_z), .alu_zero(alu_flag_reg[3]), .alu_sign(alu_flag_reg[2]),
        .alu_ovf(alu_flag_reg[1]), .alu_carry(alu_flag_reg[0]),
        .dbg_state(dbg_state)
    );

    // Behavioural ALU: returns {Z,S,V,C, z}.
    function automatic logic [11:0] alu_ref(input logic [2:0] f, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
        logic [8:0]    w;
        logic [DW-1:0] z;
        logic          c, v;
        c = 1'b0;
        v = 1'b0;
        case (f)
            3'd0: begin
                w = {1'b0, x} + {1'b0, y};
                z = w[7:0];
                c = w[8];
                v = (x[7] == y[7]) && (z[7] != x[7]);
            end
            3'd1: begin
                z = x - y;
                c = (x < y);
                v = (x[7] != y[7]) && (z[7] != x[7]);
            end
            3'd2: z = 8'((int'(x) * int'(y)) % 256);
            3'd3: z = (y == 0) ? 8'hFF : x / y;
            3'd4: z = x & y;
            3'd5: z = x | y;
            3'd6: begin
                z = {x[6:0], 1'b0};
                c = x[7];
            end
            default: z = x ^ y;
        endcase
        return {(z == 0), z[7], v, c, z};
    endfunction

    assign alu_out = alu_ref(alu_func, alu_x, alu_y);
    assign alu_z   = alu_out[7:0];
    always @(posedge clk) if (alu_update) alu_flag_reg <= alu_out[11:8];

    // ---------------- reference model / scoreboard ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_last   = 1;
    logic [3:0] m_alu_flags = 4'd0;
    logic [3:0] m_out_flags = 4'd0;
    op_t  q0[$];
    op_t  q1[$];
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_guard(input op_t o);
`ifdef ALU_DIV_GUARD_EN
        return (o.f == 3'd3) && (o.b == 0);
`else
        return (o.f == 3'd7) && 1'b0 && o.u;
`endif
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.f = 3'($urandom_range(0, 7));
        o.a = 8'($urandom_range(0, 255));
        o.b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        o.u = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // Applies one completed operation to the model; returns expected result.
    function automatic logic [DW-1:0] model_complete(input int p, input op_t o);
        logic [11:0] r;
        r = alu_ref(o.f, o.a, o.b);
        m_last = p;
        if (is_guard(o)) begin
            m_out_flags = 4'b0010;
            return 8'hFF;
        end
        if (o.u) m_alu_flags = r[11:8];
        m_out_flags = m_alu_flags;
        return r[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load(input int p, input op_t o);
        if (p == 0) begin
            func0 = o.f; a0 = o.a; b0 = o.b; upd0 = o.u; req0 = 1'b1;
        end else begin
            func1 = o.f; a1 = o.a; b1 = o.b; upd1 = o.u; req1 = 1'b1;
        end
    endtask

    task automatic wait_ack(input int scr, output bit got, output int cyc,
                            output int upd_cnt, output bit overlap);
        got = 0; cyc = 0; upd_cnt = 0; overlap = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (alu_update) upd_cnt++;
            if (ack0 && ack1) overlap = 1;
            if (ack0 || ack1) got = 1;
            else if (cyc == 1 && scr >= 0) load(scr, rand_op());
        end
    endtask

    task automatic do_single(input int p, input op_t o);
        bit got, ov;
        int cyc, uc;
        logic [3:0] prev_flags;
        @(negedge clk);
        load(p, o);
        wait_ack(p, got, cyc, uc, ov);
        check("single_ack_seen", 32'(got), 32'd1);
        check("single_latency", 32'(cyc), is_guard(o) ? 32'd1 : 32'(HOLD + 2));
        check("single_ack_port", {30'd0, ack1, ack0}, (p == 1) ? 32'd2 : 32'd1);
        check("single_upd_cycles", 32'(uc), (o.u && !is_guard(o)) ? 32'd1 : 32'd0);
        check("single_flags_hold", 32'(flags), 32'(m_out_flags));
        prev_flags = m_out_flags;
        exp_q.push_back(model_complete(p, o));
        check("single_result", 32'(result), 32'(exp_q.pop_front()));
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        check("single_flags_new", 32'(flags), 32'(m_out_flags));
        check("single_idle", {30'd0, busy, ack0 | ack1}, 32'd0);
    endtask

    task automatic run_contested();
        bit got, ov;
        int cyc, uc, ep;
        op_t o;
        @(negedge clk);
        if (q0.size() > 0) load(0, q0[0]);
        if (q1.size() > 0) load(1, q1[0]);
        while (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) ep = 1 - m_last;
            else ep = (q0.size() > 0) ? 0 : 1;
            o = (ep == 0) ? q0[0] : q1[0];
            wait_ack(-1, got, cyc, uc, ov);
            check("rr_ack_seen", 32'(got), 32'd1);
            if (!got) break;
            check("rr_grant_port", {30'd0, ack1, ack0}, (ep == 1) ? 32'd2 : 32'd1);
            check("rr_no_overlap", 32'(ov), 32'd0);
            check("rr_upd_cycles", 32'(uc), (o.u && !is_guard(o)) ? 32'd1 : 32'd0);
            check("rr_flags_hold", 32'(flags), 32'(m_out_flags));
            exp_q.push_back(model_complete(ep, o));
            check("rr_result", 32'(result), 32'(exp_q.pop_front()));
            if (ep == 0) begin
                void'(q0.pop_front());
                if (q0.size() > 0) load(0, q0[0]); else req0 = 1'b0;
            end else begin
                void'(q1.pop_front());
                if (q1.size() > 0) load(1, q1[0]); else req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("rr_flags_new", 32'(flags), 32'(m_out_flags));
        check("rr_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        op_t o;
        rst = 1'b1;
        req0 = 0; req1 = 0; upd0 = 0; upd1 = 0;
        func0 = 0; func1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
        #1;
        check("reset_outputs", {7'd0, ack0, ack1, busy, alu_update, result, alu_func, flags},
              32'd0);
        check("reset_alu_xy", {16'd0, alu_x, alu_y}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Both raised together after reset: port 0 first, then port 1 (10-10=0).
        q0.push_back('{f: 3'd0, a: 8'h21, b: 8'h02, u: 1'b1});
        q1.push_back('{f: 3'd1, a: 8'h10, b: 8'h10, u: 1'b1});
        run_contested();

        do_single(0, '{f: 3'd0, a: 8'h05, b: 8'h03, u: 1'b1});
        do_single(1, '{f: 3'd4, a: 8'hF0, b: 8'h3C, u: 1'b0});

        // Both held for 6 operations.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        run_contested();

        // Divide by zero.
        do_single(0, '{f: 3'd3, a: 8'h40, b: 8'h00, u: 1'b1});

        for (int i = 0; i < 8; i++) do_single(int'($urandom_range(0, 1)), rand_op());

        // Reset while in ISSUE.
        @(negedge clk);
        load(0, '{f: 3'd5, a: 8'h5A, b: 8'hA5, u: 1'b1});
        @(negedge clk);
        check("issue_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midop_reset_outputs",
              {7'd0, ack0, ack1, busy, alu_update, result, alu_func, flags}, 32'd0);
        check("midop_reset_alu_xy", {16'd0, alu_x, alu_y}, 32'd0);
        req0 = 1'b0;
        m_last = 1;
        m_out_flags = 4'd0;
        @(negedge clk);
        check("midop_no_ack", {30'd0, ack0, ack1}, 32'd0);
        rst = 1'b0;
        q0.push_back(rand_op());
        q1.push_back(rand_op());
        run_contested();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
